// File: rtl/edge_event_arbiter_pkg.sv
// rtl/edge_event_arbiter_pkg.sv - shared constants and helpers for the edge event arbiter
package edge_evt_pkg;

    localparam int DEF_N           = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int ARM_W           = 8;

    function automatic int chan_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// rtl/edge_event_arbiter_if.sv - event valid/ready handshake bundle
interface edge_event_arbiter_if #(
    parameter int CHAN_W = 2
);
    logic              ev_valid;
    logic              ev_ready;
    logic [CHAN_W-1:0] ev_chan;

    modport master (output ev_valid, output ev_chan, input ev_ready);
    modport slave  (input ev_valid, input ev_chan, output ev_ready);
endinterface

// File: rtl/edge_event_arbiter_rr_arbiter.sv
// rtl/edge_event_arbiter_rr_arbiter.sv - combinational round-robin selector starting at ptr
module rr_arbiter
    import edge_evt_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]            req,
    input  logic [chan_w(N)-1:0]    ptr,
    output logic [chan_w(N)-1:0]    sel,
    output logic                    any
);
    localparam int CHAN_W = chan_w(N);

    always_comb begin
        int idx;
        sel = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any = 1'b1;
                sel = CHAN_W'(idx);
            end
        end
    end
endmodule

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - synchronised edge detection, per-channel pending queue, round-robin event output
// Optional BOTH_EDGES_EN adds fall_en for per-channel falling-edge detection.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            in_sig,
`ifdef BOTH_EDGES_EN
    input  logic [N-1:0]            fall_en,
`endif
    edge_event_arbiter_if.master    ev,
    output logic [N-1:0]            pending,
    output logic [N-1:0]            overrun,
    input  logic [N-1:0]            clr_overrun
);
    localparam int CHAN_W = chan_w(N);

    logic [N-1:0]       sync_q [SYNC_STAGES];
    logic [N-1:0]       sync;
    logic [N-1:0]       prev;
    logic [N-1:0]       raw_edge;
    logic [N-1:0]       edge_det;
    logic [N-1:0]       load_vec;
    logic [ARM_W-1:0]   arm_cnt;
    logic               armed;
    logic [CHAN_W-1:0]  ptr;
    logic [CHAN_W-1:0]  sel;
    logic               any;
    logic               load;
    logic               valid_q;
    logic [CHAN_W-1:0]  chan_q;

    assign sync  = sync_q[SYNC_STAGES-1];
    assign armed = (arm_cnt == ARM_W'(SYNC_STAGES + 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev    <= '0;
            arm_cnt <= '0;
        end else begin
            sync_q[0] <= in_sig;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev <= sync;
            if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
        end
    end

`ifdef BOTH_EDGES_EN
    assign raw_edge = (sync & ~prev) | (~sync & prev & fall_en);
`else
    assign raw_edge = sync & ~prev;
`endif
    // Until the synchroniser has flushed, levels present at reset release must not look like edges.
    assign edge_det = armed ? raw_edge : '0;

    rr_arbiter #(.N(N)) u_rr (
        .req (pending),
        .ptr (ptr),
        .sel (sel),
        .any (any)
    );

    assign load = (!valid_q || ev.ev_ready) && any;

    always_comb begin
        load_vec = '0;
        if (load) load_vec[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            overrun <= '0;
            valid_q <= 1'b0;
            chan_q  <= '0;
            ptr     <= '0;
        end else begin
            // An edge landing on the cycle its channel is loaded re-arms pending without counting as overrun.
            pending <= (pending & ~load_vec) | edge_det;
            overrun <= (overrun & ~clr_overrun) | (edge_det & pending & ~load_vec);
            if (load) begin
                valid_q <= 1'b1;
                chan_q  <= sel;
                ptr     <= (sel == CHAN_W'(N - 1)) ? '0 : sel + CHAN_W'(1);
            end else if (!valid_q || ev.ev_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign ev.ev_valid = valid_q;
    assign ev.ev_chan  = chan_q;
endmodule
